// File: rtl/reference_pipe_register.sv
// Bank of CHANNELS independent DEPTH-stage clock-enabled delay lines with a
// configurable init value, selectable active edge and per-channel fill tracking.
module reference_pipe_register #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int CHANNELS   = 1,
    parameter     EDGE_SENSE = "POSEDGE",
    parameter     INIT_VALUE = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] d,
    output logic [CHANNELS*DATA_WIDTH-1:0] q,
    output logic [CHANNELS-1:0]            q_valid
);

    localparam int                    CW     = $clog2(DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] INIT_W = DATA_WIDTH'(INIT_VALUE);
    localparam logic [CW-1:0]         FULL   = CW'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reference_pipe_register: DEPTH must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("reference_pipe_register: CHANNELS must be >= 1");
    end

    // Stages hold data XOR INIT_W in two-state storage: the power-up zero then
    // reads back as INIT_VALUE, so q is defined before the first edge.
    bit [CHANNELS-1:0][DEPTH-1:0][DATA_WIDTH-1:0] stage_q, stage_d;
    bit [CHANNELS-1:0][CW-1:0]                    fill_q, fill_d;

    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (en[c]) begin
                stage_d[c][0] = d[c*DATA_WIDTH +: DATA_WIDTH] ^ INIT_W;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_d[c][k] = stage_q[c][k-1];
                end
                if (fill_q[c] != FULL) begin
                    fill_d[c] = fill_q[c] + CW'(1);
                end
            end
        end
    end

    if (EDGE_SENSE == "POSEDGE") begin : g_posedge
        always_ff @(posedge clock) begin
            if (reset) begin
                stage_q <= '0;
                fill_q  <= '0;
            end else begin
                stage_q <= stage_d;
                fill_q  <= fill_d;
            end
        end
    end else if (EDGE_SENSE == "NEGEDGE") begin : g_negedge
        always_ff @(negedge clock) begin
            if (reset) begin
                stage_q <= '0;
                fill_q  <= '0;
            end else begin
                stage_q <= stage_d;
                fill_q  <= fill_d;
            end
        end
    end else begin : g_bad_edge
        $error("reference_pipe_register: EDGE_SENSE must be POSEDGE or NEGEDGE");
    end

    always_comb begin
        q       = '0;
        q_valid = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            q[c*DATA_WIDTH +: DATA_WIDTH] = stage_q[c][DEPTH-1] ^ INIT_W;
            q_valid[c]                    = (fill_q[c] == FULL);
        end
    end

endmodule

// File: tb/tb_reference_pipe_register.sv
// Bench for reference_pipe_register: a 2-channel DEPTH=3 posedge instance checked
// against a history-queue model, plus a DEPTH=1 negedge instance with truncated init.
module tb_reference_pipe_register;

    typedef struct packed {
        logic [15:0] q;
        logic [1:0]  qv;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic [1:0]  en    = '0;
    logic [15:0] d     = '0;
    logic [15:0] q;
    logic [1:0]  qv;

    logic        n_rst = 1'b0;
    logic [0:0]  n_en  = '0;
    logic [7:0]  n_d   = '0;
    logic [7:0]  n_q;
    logic [0:0]  n_qv;

    int unsigned checks = 0;
    int unsigned passes = 0;

    exp_t       sb[$];
    logic [7:0] h0[$];
    logic [7:0] h1[$];
    int         cnt0 = 0;
    int         cnt1 = 0;

    always #5 clock = ~clock;

    reference_pipe_register #(
        .DATA_WIDTH(8), .DEPTH(3), .CHANNELS(2),
        .EDGE_SENSE("POSEDGE"), .INIT_VALUE(8'hA5)
    ) u_dut (
        .clock(clock), .reset(rst), .en(en), .d(d), .q(q), .q_valid(qv)
    );

    reference_pipe_register #(
        .DATA_WIDTH(8), .DEPTH(1), .CHANNELS(1),
        .EDGE_SENSE("NEGEDGE"), .INIT_VALUE(16'h1FF)
    ) u_dut_neg (
        .clock(clock), .reset(n_rst), .en(n_en), .d(n_d), .q(n_q), .q_valid(n_qv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // The model keeps the last three enabled inputs per lane; the oldest is q.
    task automatic step(input logic r, input logic [1:0] e,
                        input logic [7:0] d0, input logic [7:0] d1);
        exp_t x;
        @(negedge clock);
        rst = r;
        en  = e;
        d   = {d1, d0};
        if (r) begin
            h0 = '{8'hA5, 8'hA5, 8'hA5};
            h1 = '{8'hA5, 8'hA5, 8'hA5};
            cnt0 = 0;
            cnt1 = 0;
        end else begin
            if (e[0]) begin
                h0.push_back(d0);
                void'(h0.pop_front());
                cnt0++;
            end
            if (e[1]) begin
                h1.push_back(d1);
                void'(h1.pop_front());
                cnt1++;
            end
        end
        x.q  = {h1[0], h0[0]};
        x.qv = {cnt1 >= 3, cnt0 >= 3};
        sb.push_back(x);
        @(posedge clock);
        #1;
        x = sb.pop_front();
        chk("sb_q", 32'(q), 32'(x.q));
        chk("sb_qv", 32'(qv), 32'(x.qv));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        h0 = '{8'hA5, 8'hA5, 8'hA5};
        h1 = '{8'hA5, 8'hA5, 8'hA5};

        #1;
        chk("t0_q", 32'(q), 32'hA5A5);
        chk("t0_qv", 32'(qv), 32'h0);
        chk("t0_neg_q", 32'(n_q), 32'hFF);
        chk("t0_neg_qv", 32'(n_qv), 32'h0);

        // idle edges, no reset: init contents persist
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 8'(i), 8'(i + 1));
        chk("idle_q", 32'(q), 32'hA5A5);

        // fill
        step(1'b1, 2'b11, 8'h00, 8'h00);
        step(1'b0, 2'b11, 8'h01, 8'h11);
        step(1'b0, 2'b11, 8'h02, 8'h12);
        step(1'b0, 2'b11, 8'h03, 8'h13);
        chk("fill3_q0", 32'(q[7:0]), 32'h01);
        chk("fill3_qv", 32'(qv), 32'h3);
        step(1'b0, 2'b11, 8'h04, 8'h14);
        chk("fill4_q", 32'(q), 32'h1202);

        // enable gaps
        step(1'b0, 2'b01, 8'h09, 8'($urandom));
        step(1'b0, 2'b00, 8'($urandom), 8'($urandom));
        step(1'b0, 2'b00, 8'($urandom), 8'($urandom));
        chk("gap_hold_q0", 32'(q[7:0]), 32'h03);
        chk("gap_hold_qv0", 32'(qv[0]), 32'h1);
        step(1'b0, 2'b01, 8'h0A, 8'h00);
        step(1'b0, 2'b01, 8'h0B, 8'h00);
        chk("gap_emerge_q0", 32'(q[7:0]), 32'h09);

        // reset beats en, then lanes are independent
        step(1'b1, 2'b11, 8'hFF, 8'hFF);
        chk("rst_over_en_q", 32'(q), 32'hA5A5);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 8'h07, 8'h03);
        chk("indep_q", 32'(q), 32'hA507);
        chk("indep_qv", 32'(qv), 32'h1);

        // mid-stream reset discards in-flight data
        step(1'b1, 2'b11, 8'h00, 8'h00);
        step(1'b0, 2'b11, 8'h20, 8'h20);
        step(1'b1, 2'b11, 8'h21, 8'h21);
        chk("mid_rst_q", 32'(q), 32'hA5A5);
        chk("mid_rst_qv", 32'(qv), 32'h0);
        step(1'b0, 2'b11, 8'h30, 8'h40);
        step(1'b0, 2'b11, 8'h31, 8'h41);
        chk("refill2_qv", 32'(qv), 32'h0);
        step(1'b0, 2'b11, 8'h32, 8'h42);
        chk("refill3_q", 32'(q), 32'h4030);
        chk("refill3_qv", 32'(qv), 32'h3);

        for (int i = 0; i < 30; i++) begin
            step($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom));
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // negedge instance
        rst = 1'b0;
        en  = 2'b00;
        chk("neg_idle_q", 32'(n_q), 32'hFF);
        n_en = 1'b1;
        n_d  = 8'h3C;
        #2;
        chk("neg_no_posedge_q", 32'(n_q), 32'hFF);
        @(negedge clock);
        #1;
        chk("neg_shift_q", 32'(n_q), 32'h3C);
        chk("neg_shift_qv", 32'(n_qv), 32'h1);
        n_d = 8'h77;
        @(posedge clock);
        #1;
        chk("neg_posedge_hold_q", 32'(n_q), 32'h3C);
        @(negedge clock);
        #1;
        chk("neg_next_q", 32'(n_q), 32'h77);
        @(posedge clock);
        #1;
        n_d   = 8'h5A;
        n_rst = 1'b1;
        #2;
        n_rst = 1'b0;
        @(negedge clock);
        #1;
        chk("neg_rst_pulse_q", 32'(n_q), 32'h5A);
        chk("neg_rst_pulse_qv", 32'(n_qv), 32'h1);
        n_en = 1'b0;
        n_d  = 8'h11;
        @(negedge clock);
        #1;
        chk("neg_hold_q", 32'(n_q), 32'h5A);
        n_rst = 1'b1;
        @(negedge clock);
        #1;
        chk("neg_rst_q", 32'(n_q), 32'hFF);
        chk("neg_rst_qv", 32'(n_qv), 32'h0);
        n_rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reference_pipe_register.md
Name: reference_pipe_register

Overview:
- Parametrised successor to the single-stage reference register used in midas widget reference models.
- Models a CHANNELS-wide bank of DEPTH-stage clock-enabled delay lines with selectable active edge and a configurable init value.
- Adds per-channel fill tracking (q_valid), so host-side comparators know when the reference output reflects real input rather than init contents.
- Simulation-only reference model; sits beside target-RTL models in widget testbenches.

Parameters:
- DATA_WIDTH, 8, bit width of each channel's data.
- DEPTH, 2, number of register stages per channel; must be >= 1, otherwise elaboration error.
- CHANNELS, 1, number of independent lanes; must be >= 1.
- EDGE_SENSE, "POSEDGE", active edge string, "POSEDGE" or "NEGEDGE"; any other value is an elaboration error.
- INIT_VALUE, 0, value loaded into every stage at time zero and on reset. Truncated to DATA_WIDTH if wider, zero-extended if narrower.

Ports:
- clock  in  1  single clock; only the edge selected by EDGE_SENSE is active.
- reset  in  1  synchronous, active-high, sampled on the active edge.
- en  in  CHANNELS  per-channel shift enable.
- d  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- q  out  CHANNELS*DATA_WIDTH  last stage of each channel, same packing as d.
- q_valid  out  CHANNELS  channel c has shifted at least DEPTH times since reset.

Behaviour:
- Active edge E: posedge clock for "POSEDGE", negedge clock for "NEGEDGE". All state changes only at E.
- Time zero, before any edge:
  - all stages = INIT_VALUE[DATA_WIDTH-1:0]
  - fill counters = 0, q_valid = 0
  - q is never X.
- Reset (reset=1 at E):
  - all stages of all channels <= INIT_VALUE; fill <= 0; q_valid <= 0.
  - reset overrides en.
  - Reset mid-fill or mid-stream discards all in-flight data.
- Shift (reset=0, en[c]=1 at E):
  - stage0_c <= d_c; stage k_c <= stage (k-1)_c for k = 1..DEPTH-1.
  - fill_c <= min(fill_c+1, DEPTH); counter width clog2(DEPTH+1); saturates and never wraps.
- Hold (reset=0, en[c]=0 at E): channel c stages and fill unchanged. Channels are fully independent.
- Outputs:
  - q_c = stage (DEPTH-1)_c.
  - q_valid[c] = (fill_c == DEPTH), derived from registered state, so it updates at the same E as q.
- Latency: d_c sampled at the n-th enabled edge appears on q_c immediately after the (n+DEPTH-1)-th enabled edge. DEPTH=1 matches a plain enabled register.
- Gaps: disabled edges do not count toward latency; data is not lost across en gaps.
- Edge semantics: nonblocking updates at E; d/en/reset changing coincident with E use pre-edge values.
- Inactive edge: no state change, regardless of input activity.
- NEGEDGE: reset must be held across a negedge to take effect; a reset pulse between two negedges is ignored.

Test Plan:
- DATA_WIDTH=8, DEPTH=3, CHANNELS=1, INIT_VALUE=8'hA5, no reset, en=0 -> q=8'hA5 at time zero and after 5 edges; q_valid=0.
- Same config, reset 1 cycle then en=1, d=1,2,3,4 on successive posedges -> q=A5,A5,01,02 after edges 1..4; q_valid rises with q=01 and stays 1.
- Same config after fill, en pattern 1,0,0,1 with d=9,X,X,10 -> q holds across the en=0 edges; 9 emerges after two further enabled edges; q_valid stays 1.
- CHANNELS=2, en=2'b01 for 4 edges, d0=7, d1=3 -> ch0 q=07, q_valid[0]=1; ch1 q=INIT, q_valid[1]=0.
- Mid-stream reset at edge 2 of a fill with en=1 -> next edge q=INIT, q_valid=0; refill needs 3 more enabled edges.
- EDGE_SENSE="NEGEDGE", DEPTH=1, d changed after posedge -> q updates only at the following negedge. INIT_VALUE=16'h1FF with DATA_WIDTH=8 -> init q=8'hFF.
